// File: rtl/syrk_pkg.sv
// syrk_pkg: shared widths and result-word tag layout for the SYRK collector
// Exports DATA_W (result word width), tag_t {last_row, last}, ENTRY_W (FIFO entry width).
package syrk_pkg;
    localparam int DATA_W = 32;
    typedef struct packed {
        logic last_row;
        logic last;
    } tag_t;
    localparam int ENTRY_W = DATA_W + $bits(tag_t);
endpackage

// File: rtl/syrk_collector_fifo.sv
// syrk_sync_fifo: parameterised show-ahead single-clock FIFO
// Ports: clk, rst (async active-high); wr_en/wr_data push; rd_en pops the word shown on rd_data;
// full, empty and count (occupancy) status.
module syrk_sync_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [W-1:0]           wr_data,
    input  logic                   rd_en,
    output logic [W-1:0]           rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem [DEPTH];
    logic         do_wr, do_rd;
    always_comb begin
        empty    = wr_ptr_q == rd_ptr_q;
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_rd    = rd_en && !empty;
        // a pop in the same cycle frees the slot the push needs
        do_wr    = wr_en && (!full || do_rd);
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_wr);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_rd);
        count    = wr_ptr_q - rd_ptr_q;
        rd_data  = mem[rd_ptr_q[AW-1:0]];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/syrk_result_collector.sv
// syrk_result_collector: aligns, tags and buffers the SYRK engine result stream onto a valid/ready port
// Ports: clk, rst (async active-high); Din/flag from the engine; m_data/m_valid/m_ready/m_last_row/m_last
// output stream; words_out (pops this frame), overflow (sticky drop), done (last word popped).
// Optional macro SYRK_COLLECT_CKSUM_EN adds cksum/cksum_valid, a mod-2^32 sum of each popped frame.
module syrk_result_collector
    import syrk_pkg::*;
#(
    parameter int SIZE   = 100,
    parameter int RD_LAT = 1,
    parameter int DEPTH  = 256,
    parameter int CW     = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] Din,
    input  logic              flag,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last_row,
    output logic              m_last,
    output logic [CW-1:0]     words_out,
    output logic              overflow,
    output logic              done
`ifdef SYRK_COLLECT_CKSUM_EN
    ,
    output logic [DATA_W-1:0] cksum,
    output logic              cksum_valid
`endif
);
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);
    logic [RD_LAT-1:0]      flag_dl_q, flag_dl_d;
    logic [CW-1:0]          row_q, row_d, col_q, col_d, words_q, words_d;
    logic                   ovf_q, ovf_d, done_q, done_d;
    logic                   push_en, pop, full, empty;
    tag_t                   wr_tag, rd_tag;
    logic [ENTRY_W-1:0]     rd_entry;
    logic [$clog2(DEPTH):0] unused_count;
    syrk_sync_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_en),
        .wr_data ({Din, wr_tag}),
        .rd_en   (pop),
        .rd_data (rd_entry),
        .full    (full),
        .empty   (empty),
        .count   (unused_count)
    );
    always_comb begin
        flag_dl_d       = RD_LAT'({flag_dl_q, flag});
        push_en         = flag_dl_q[RD_LAT-1];
        wr_tag.last_row = col_q == LAST;
        wr_tag.last     = wr_tag.last_row && row_q == LAST;
        rd_tag          = tag_t'(rd_entry[$bits(tag_t)-1:0]);
        m_data          = rd_entry[ENTRY_W-1:$bits(tag_t)];
        m_valid         = !empty;
        // stale tags in an empty FIFO slot must not leak out
        m_last_row      = m_valid && rd_tag.last_row;
        m_last          = m_valid && rd_tag.last;
        pop             = m_valid && m_ready;
        // position tracks every engine word, dropped or not
        col_d           = push_en ? (wr_tag.last_row ? '0 : col_q + CW'(1)) : col_q;
        row_d           = (push_en && wr_tag.last_row) ? (wr_tag.last ? '0 : row_q + CW'(1)) : row_q;
        words_d         = pop ? (m_last ? '0 : words_q + CW'(1)) : words_q;
        ovf_d           = ovf_q || (push_en && full && !pop);
        done_d          = (pop && m_last) ? 1'b1 : (push_en ? 1'b0 : done_q);
        words_out       = words_q;
        overflow        = ovf_q;
        done            = done_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_dl_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
            words_q   <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            flag_dl_q <= flag_dl_d;
            row_q     <= row_d;
            col_q     <= col_d;
            words_q   <= words_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end
`ifdef SYRK_COLLECT_CKSUM_EN
    logic [DATA_W-1:0] acc_q, acc_d, cksum_q, cksum_d;
    logic              cv_q, cv_d;
    always_comb begin
        acc_d       = pop ? (m_last ? '0 : acc_q + m_data) : acc_q;
        cksum_d     = (pop && m_last) ? acc_q + m_data : cksum_q;
        cv_d        = pop && m_last;
        cksum       = cksum_q;
        cksum_valid = cv_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            cksum_q <= '0;
            cv_q    <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cksum_q <= cksum_d;
            cv_q    <= cv_d;
        end
    end
`endif
endmodule

// File: tb/tb_syrk_result_collector.sv
// tb_syrk_result_collector: directed self-checking bench for syrk_result_collector (SIZE=4, DEPTH=8)
module tb_syrk_result_collector;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] Din = '0;
    logic        flag = 1'b0;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic        m_valid, m_last_row, m_last, overflow, done;
    logic [13:0] words_out;
    int          n_cmp = 0;
    int          n_err = 0;
`ifdef SYRK_COLLECT_CKSUM_EN
    logic [31:0] cksum;
    logic        cksum_valid;
`endif
    syrk_result_collector #(.SIZE(4), .RD_LAT(1), .DEPTH(8), .CW(14)) dut (
        .clk        (clk),
        .rst        (rst),
        .Din        (Din),
        .flag       (flag),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last_row (m_last_row),
        .m_last     (m_last),
        .words_out  (words_out),
        .overflow   (overflow),
        .done       (done)
`ifdef SYRK_COLLECT_CKSUM_EN
        ,
        .cksum       (cksum),
        .cksum_valid (cksum_valid)
`endif
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // one 16-word frame with m_ready=1; skip0 when the previous frame already raised flag,
    // more to keep flag high on the last step for a 1-cycle inter-frame gap
    task automatic run_frame(input bit skip0, input bit more);
        for (int i = (skip0 ? 1 : 0); i <= 17; i++) begin
            flag    = (i < 16) || (i == 17 && more);
            Din     = (i >= 1 && i <= 16) ? i : 0;
            m_ready = 1'b1;
            tick();
            if (i >= 1 && i <= 16) begin
                chk("frm_valid", m_valid, 1);
                chk("frm_data", m_data, i);
                chk("frm_last_row", m_last_row, (i % 4) == 0);
                chk("frm_last", m_last, i == 16);
                chk("frm_words_out", words_out, i - 1);
                chk("frm_done_low", done, 0);
`ifdef SYRK_COLLECT_CKSUM_EN
                chk("frm_cksum_valid_low", cksum_valid, 0);
`endif
            end
            if (i == 17) begin
                chk("frm_end_valid", m_valid, 0);
                chk("frm_end_done", done, 1);
                chk("frm_end_words_out", words_out, 0);
                chk("frm_end_overflow", overflow, 0);
`ifdef SYRK_COLLECT_CKSUM_EN
                chk("frm_cksum", cksum, 136);
                chk("frm_cksum_valid", cksum_valid, 1);
`endif
            end
        end
    endtask
    initial begin
        #1;
        chk("rst_valid", m_valid, 0);
        chk("rst_words_out", words_out, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_done", done, 0);
        chk("rst_last", m_last, 0);
        chk("rst_last_row", m_last_row, 0);
        tick();
        rst = 1'b0;
        run_frame(0, 0);
        // no consumer: 8 words fit, the remaining 8 are dropped
        m_ready = 1'b0;
        for (int i = 0; i <= 17; i++) begin
            flag = i < 16;
            Din  = i;
            tick();
            if (i == 8) chk("ovf_before_drop", overflow, 0);
            if (i == 9) chk("ovf_on_drop", overflow, 1);
        end
        chk("ovf_valid", m_valid, 1);
        chk("ovf_head", m_data, 1);
        chk("ovf_sticky", overflow, 1);
        chk("ovf_done", done, 0);
        for (int k = 1; k <= 8; k++) begin
            chk("ovf_drain_data", m_data, k);
            chk("ovf_drain_last_row", m_last_row, (k % 4) == 0);
            chk("ovf_drain_last", m_last, 0);
            m_ready = 1'b1;
            tick();
        end
        chk("ovf_drained", m_valid, 0);
        chk("ovf_words_out", words_out, 8);
        chk("ovf_still_set", overflow, 1);
        // full FIFO with simultaneous push and pop
        rst = 1'b1;
        #1;
        chk("rst2_overflow", overflow, 0);
        tick();
        rst = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            flag = 1'b1;
            Din  = 32'h10 + i;
            tick();
        end
        chk("full_valid", m_valid, 1);
        chk("full_head", m_data, 32'h11);
        chk("full_no_ovf", overflow, 0);
        Din     = 32'hAA;
        flag    = 1'b0;
        m_ready = 1'b1;
        tick();
        chk("fullrw_overflow", overflow, 0);
        chk("fullrw_head", m_data, 32'h12);
        chk("fullrw_words_out", words_out, 1);
        for (int k = 2; k <= 9; k++) begin
            chk("fullrw_valid", m_valid, 1);
            chk("fullrw_data", m_data, (k == 9) ? 32'hAA : 32'h10 + k);
            chk("fullrw_last_row", m_last_row, (k % 4) == 0);
            tick();
        end
        chk("fullrw_drained", m_valid, 0);
        chk("fullrw_count", words_out, 9);
        chk("fullrw_no_ovf", overflow, 0);
        // reset mid-frame after 5 pushes
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            flag = i < 5;
            Din  = i;
            tick();
        end
        chk("mid_words_out", words_out, 4);
        chk("mid_valid", m_valid, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_words_out", words_out, 0);
        chk("mid_rst_last", m_last, 0);
        tick();
        rst = 1'b0;
        run_frame(0, 0);
        // back-to-back frames separated by one idle flag cycle
        run_frame(0, 1);
        run_frame(1, 0);
        flag = 1'b0;
        tick();
        chk("b2b_done_hold", done, 1);
`ifdef SYRK_COLLECT_CKSUM_EN
        chk("b2b_cksum_pulse", cksum_valid, 0);
        chk("b2b_cksum_hold", cksum, 136);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/syrk_result_collector.md
Name: syrk_result_collector

Overview:
- Downstream stage of the SYRK matrix engine.
- Captures the engine's result stream (32-bit Dout, qualified by flag), aligns data to the engine's RAM read latency, tags row/matrix boundaries, and buffers words in a FIFO.
- Presents the buffered words on a valid/ready stream to the host-side consumer.
- Decouples the engine's free-running, non-stallable output from a back-pressuring consumer.

Parameters:
- SIZE, 100, matrix dimension; one frame is SIZE*SIZE words, row-major.
- RD_LAT, 1, cycles between flag assertion and the corresponding valid word on Din.
- DEPTH, 256, FIFO entries; must be a power of two and at least 2.
- CW, 14, width of the row, column and word counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- Din  in  32  result word from engine Dout
- flag  in  1  engine output-phase flag; a word is valid RD_LAT cycles after each high cycle
- m_data  out  32  output word
- m_valid  out  1  output word available
- m_ready  in  1  consumer accepts the word
- m_last_row  out  1  m_data is the last column of its row
- m_last  out  1  m_data is the final word of the frame
- words_out  out  CW  count of words popped in the current frame
- overflow  out  1  sticky: a word was dropped because the FIFO was full
- done  out  1  final word of the frame has been popped

Behaviour:
- Reset, asynchronous, takes effect immediately: flag delay line=0, row=col=0, FIFO empty, m_valid=0, m_last_row=0, m_last=0, words_out=0, overflow=0, done=0. Reset mid-frame discards all buffered data.
- Capture: flag passes through an RD_LAT-stage shift register; its output is push_en. When push_en=1, Din is written together with the tags {last_row = (col==SIZE-1), last = (row==SIZE-1 && col==SIZE-1)}. Each FIFO entry is 34 bits.
- Counters advance on every push_en cycle, including dropped words, so the row/column position stays locked to the engine stream. col wraps at SIZE-1 and increments row. After the last word, row and col return to 0 for the next frame.
- FIFO: read and write pointers are log2(DEPTH)+1 bits wide.
  - empty when the pointers are equal.
  - full when the MSBs differ and the remaining bits are equal.
  - Show-ahead: m_valid = !empty; m_data and tags come from mem[rd_ptr] combinationally.
- Pop: occurs when m_valid && m_ready. rd_ptr increments and words_out increments.
- Simultaneous push and pop when full: the push is accepted and occupancy is unchanged.
- Push when full with no pop: Din is dropped, write pointer is held, overflow is set to 1. overflow stays set until reset.
- Pop while empty: no effect; m_ready is ignored.
- done:
  - set on the cycle after the pop of a word tagged last; words_out resets to 0 on that same pop.
  - cleared on the next push_en.
- Latency: a word is visible on m_valid 1 cycle after its push_en cycle, since the write is registered. Throughput is 1 word/cycle.

Optional Feature:
- Macro: SYRK_COLLECT_CKSUM_EN
- Defined:
  - extra ports: cksum out 32 and cksum_valid out 1.
  - cksum accumulates a mod-2^32 sum of every popped m_data in the frame.
  - On the pop of the last word, the sum including that word is registered; cksum_valid pulses high for 1 cycle with done.
  - The accumulator clears after that pop and on reset.
- Undefined: the ports and logic are absent and the rest of the behaviour is identical.

Decomposition:
- Shared package syrk_pkg holds:
  - data width constant DATA_W=32.
  - tag struct typedef {last_row, last}.
  - FIFO entry width constant ENTRY_W = DATA_W + 2.
- One natural sub-module: syrk_sync_fifo, a parameterised show-ahead single-clock FIFO exposing full, empty and a count.
- Capture alignment, counters, overflow/done logic and the checksum remain in the top module.

Test Plan:
- SIZE=4, RD_LAT=1, m_ready=1. Drive flag high for 16 cycles with Din=1..16 lagging by 1 cycle.
  - m_data = 1..16 in order.
  - m_last_row high on 4, 8, 12, 16; m_last high only on 16.
  - done high the cycle after 16 pops; overflow=0.
- SIZE=4, DEPTH=8, m_ready=0 throughout the 16-word frame.
  - 8 words buffered; overflow=1.
  - Releasing m_ready yields words 1..8; m_last is never seen.
- DEPTH=8 with the FIFO full. Push Din=0xAA with m_ready=1 in the same cycle.
  - 0xAA is accepted with no overflow.
  - Occupancy remains 8; the oldest word is popped.
- Assert rst mid-frame after 5 pushes.
  - m_valid=0 and words_out=0 immediately.
  - A subsequent full 16-word frame tags correctly from word 1.
- Run two back-to-back frames with a 1-cycle flag gap.
  - done rises after frame 1 and clears on the first push of frame 2.
  - Tags of frame 2 are correct.
- With SYRK_COLLECT_CKSUM_EN, SIZE=4 and Din=1..16:
  - cksum=136 with cksum_valid pulsed once.
  - A second identical frame again reports 136.
